// File: rtl/gpio_pkg.sv
// Shared field layout, reset value, FSM/grant encodings and data helpers
// for the GPIO/LED write arbiter.
package gpio_pkg;

  localparam int GPIO_HI = 31;
  localparam int GPIO_LO = 10;
  localparam int LED_HI  = 9;
  localparam int LED_LO  = 2;
  localparam int CSET_HI = 1;
  localparam int CSET_LO = 0;

  localparam logic [31:0] RESET_VAL_DEF = 32'h0000_02A8;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_e;
  typedef enum logic [0:0] {GNT_CPU = 1'b0, GNT_PAT = 1'b1} gnt_e;

  function automatic logic [31:0] mask_expand(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // LED field rotates left by one; bit LED_HI wraps to LED_LO.
  function automatic logic [31:0] led_rotl(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    r[LED_HI:LED_LO] = {w[LED_HI-1:LED_LO], w[LED_HI]};
    return r;
  endfunction

endpackage

// File: rtl/gpio_wr_arbiter_if.sv
// CPU write handshake into the arbiter: level request held until a
// one-cycle ack.
interface gpio_wr_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_mask;
  logic        cpu_ack;

  modport master (output cpu_req, cpu_wdata, cpu_mask, input cpu_ack);
  modport slave  (input cpu_req, cpu_wdata, cpu_mask, output cpu_ack);
endinterface

// File: rtl/gpio_pat_timer.sv
// Free-running step timer for the LED rotate pattern; raises a single
// sticky pending flag on each wrap.
module gpio_pat_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pat_en,
  input  logic [15:0] pat_period,
  input  logic        pat_clr,
  output logic        pat_pend
);

  logic [15:0] cnt;
  logic        pend_q;
  logic        wrap;

  // >= keeps the timer sane if pat_period is lowered below the current count.
  assign wrap = (cnt >= pat_period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pend_q <= 1'b0;
    end else if (!pat_en) begin
      cnt    <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt    <= wrap ? 16'd0 : cnt + 16'd1;
      pend_q <= wrap | (pend_q & ~pat_clr);
    end
  end

  // Gated so a pending step dies in the same cycle pat_en drops.
  assign pat_pend = pend_q & pat_en;

endmodule

// File: rtl/gpio_wr_arbiter.sv
// Two-state write arbiter between CPU masked writes and the LED pattern
// engine; keeps a shadow of the last word written to the device.
module gpio_wr_arbiter
  import gpio_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_VAL_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  gpio_wr_arbiter_if.slave   cpu,
  input  logic               pat_en,
  input  logic [15:0]        pat_period,
  output logic               gpio_we,
  output logic [31:0]        gpio_wdata,
  output logic [31:0]        shadow,
  output logic               busy
);

  localparam logic [0:0] IDLE  = S_IDLE;
  localparam logic [0:0] ISSUE = S_ISSUE;

  logic [0:0]  state;
  gnt_e        last_gnt;
  logic        ack_q;
  logic        pat_pend;
  logic        pat_clr;
  logic        take;
  logic        gnt_cpu;
  logic [31:0] cpu_word;
  logic [31:0] pat_word;
  logic [31:0] m;

  gpio_pat_timer u_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .pat_en     (pat_en),
    .pat_period (pat_period),
    .pat_clr    (pat_clr),
    .pat_pend   (pat_pend)
  );

  // On a tie the requester not granted last wins.
  always_comb begin
    take    = (state == IDLE) && (cpu.cpu_req || pat_pend);
    gnt_cpu = cpu.cpu_req && (!pat_pend || last_gnt == GNT_PAT);
    pat_clr = take && !gnt_cpu;
    m        = mask_expand(cpu.cpu_mask);
    cpu_word = (shadow & ~m) | (cpu.cpu_wdata & m);
    pat_word = led_rotl(shadow);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_gnt   <= GNT_PAT;
      gpio_we    <= 1'b0;
      ack_q      <= 1'b0;
      gpio_wdata <= RESET_VAL;
      shadow     <= RESET_VAL;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state      <= ISSUE;
            gpio_we    <= 1'b1;
            ack_q      <= gnt_cpu;
            last_gnt   <= gnt_cpu ? GNT_CPU : GNT_PAT;
            gpio_wdata <= gnt_cpu ? cpu_word : pat_word;
          end
        end
        default: begin
          state   <= IDLE;
          gpio_we <= 1'b0;
          ack_q   <= 1'b0;
          shadow  <= gpio_wdata;
        end
      endcase
    end
  end

  assign cpu.cpu_ack = ack_q;
  assign busy        = (state == ISSUE);

endmodule

// File: doc/gpio_wr_arbiter.md
GPIO_WR_ARBITER -- requirements
Module: gpio_wr_arbiter

Interface
REQ-001 SHALL have parameter: RESET_VAL, 32'h0000_02A8, shadow/output value after reset (LED field = 8'hAA, counter_set = 0, GPIO field = 0).
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cpu_req  in  1  CPU write request, level, held until cpu_ack.
REQ-005 SHALL have port: cpu_wdata  in  32  CPU write data.
REQ-006 SHALL have port: cpu_mask  in  4  byte enables for cpu_wdata (bit i covers [8i+7:8i]).
REQ-007 SHALL have port: cpu_ack  out  1  one-cycle pulse when CPU write is issued.
REQ-008 SHALL have port: pat_en  in  1  enables LED rotate pattern engine.
REQ-009 SHALL have port: pat_period  in  16  pattern step interval minus one, in cycles.
REQ-010 SHALL have port: gpio_we  out  1  write strobe to LED/GPIO device.
REQ-011 SHALL have port: gpio_wdata  out  32  write word {GPIO[31:10], LED[9:2], counter_set[1:0]}.
REQ-012 SHALL have port: shadow  out  32  last value written to device.
REQ-013 SHALL have port: busy  out  1  high while in ISSUE state.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE; IDLE->ISSUE when any request pending at posedge; ISSUE->IDLE unconditionally.
REQ-015 SHALL, in ISSUE, assert gpio_we=1 for exactly one cycle with gpio_wdata stable; gpio_we=0 in IDLE.
REQ-016 SHALL have latency one cycle: request sampled in IDLE at edge k -> gpio_we high in cycle k+1; maximum throughput one write per two cycles.
REQ-017 SHALL, for CPU grant, drive gpio_wdata = (shadow & ~M) | (cpu_wdata & M), M = byte mask expanded from cpu_mask; cpu_ack high in same cycle as gpio_we.
REQ-018 SHALL treat cpu_mask=0 as a valid write: gpio_wdata = shadow, write and ack still occur.
REQ-019 SHALL, for pattern grant, drive gpio_wdata = shadow with bits [9:2] rotated left by one (bit 9 -> bit 2); other bits unchanged.
REQ-020 SHALL update shadow to gpio_wdata at the posedge ending the ISSUE cycle.
REQ-021 SHALL run a 16-bit pattern timer while pat_en=1: counts 0..pat_period, wraps to 0, sets pat_pend on wrap; pat_period=0 wraps every cycle.
REQ-022 SHALL hold timer at 0 and clear pat_pend while pat_en=0.
REQ-023 SHALL keep a single pat_pend flag; wrap while pat_pend already set is dropped (no queueing).
REQ-024 SHALL clear pat_pend on pattern grant; wrap in the same cycle as grant sets pat_pend again.
REQ-025 SHALL arbitrate round-robin when both pending in IDLE: grant the requester not granted last; single pending requester always wins.
REQ-026 SHALL record last grant on every IDLE->ISSUE transition.
REQ-027 SHALL treat cpu_req still high in the IDLE cycle after cpu_ack as a new request.
REQ-028 SHALL ignore cpu_wdata/cpu_mask changes during ISSUE (values latched at grant edge).

Reset
REQ-029 SHALL, on rst_n low, asynchronously force: state=IDLE, gpio_we=0, cpu_ack=0, busy=0, gpio_wdata=RESET_VAL, shadow=RESET_VAL, timer=0, pat_pend=0, last grant=pattern (CPU wins first tie).
REQ-030 SHALL abort an in-progress ISSUE on reset with no shadow update and no ack.
REQ-031 SHALL leave reset synchronously: first request accepted at first posedge with rst_n high.

Structure
REQ-032 SHALL place in shared package gpio_pkg: field bounds (LED 9:2, counter_set 1:0, GPIO 31:10), RESET_VAL default, state enum, grant-id enum.
REQ-033 SHALL split the pattern timer and pat_pend flag into sub-module gpio_pat_timer; arbiter, FSM and shadow stay in gpio_wr_arbiter.

Verification
REQ-034 SHALL cover reset: rst_n low mid-ISSUE -> gpio_we=0 immediately, shadow=32'h2A8, no cpu_ack.
REQ-035 SHALL cover masked CPU write: shadow=32'h2A8, cpu_wdata=32'hFFFF_FF55, mask=4'b0001 -> gpio_wdata=32'h0000_0255 one cycle after req, cpu_ack=1.
REQ-036 SHALL cover pattern: pat_en=1, pat_period=3 -> gpio_we every 4 cycles, LED field AA->55->AA, bits [1:0],[31:10] unchanged.
REQ-037 SHALL cover tie: cpu_req and pat_pend both set after reset -> CPU granted first, pattern next ISSUE, then alternate while both remain pending.
REQ-038 SHALL cover overflow: pat_period=0, cpu_req held continuously -> alternating grants, exactly one pattern write per two ISSUEs, no extra pattern writes.
REQ-039 SHALL cover pat_en drop with pat_pend set -> no pattern write issued, timer reads 0.
